sobel_window_ctrl: RTL
======================

// Module: sobel_window_ctrl
// PURPOSE
//  Sequences the 3x3 Sobel edge datapath from a raster gray-pixel stream.
//  Holds two line buffers and a 3x3 shift window, and tracks column/row position.
//  Presents the nine taps data00..data22 to the downstream Sobel filter together
//  with a window-valid strobe and centre coordinates.
//  Sits between the gray converter and the Sobel filter in the VGA capture path.
// PARAMETERS
//  H_ACT  640  active pixels per line (>=3)
//  V_ACT  480  active lines per frame (>=3)
//  DW     16   gray pixel width
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high
//  sof         in   1      start-of-frame pulse; may coincide with the first pixel
//  pix_valid   in   1      pixel qualifier
//  pix_data    in   DW     gray pixel, raster order
//  data00..22  out  DW x9  window taps, row r (0=oldest line), column c (0=oldest)
//  win_valid   out  1      taps valid for the centre pixel this cycle
//  win_x       out  10     centre column (1..H_ACT-2)
//  win_y       out  9      centre row (1..V_ACT-2)
//  busy        out  1      high in FILL/RUN
//  frame_done  out  1      one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  - Reset: all outputs 0. Taps, counters and state are cleared; state=IDLE.
//    Line-buffer contents are don't-care.
//  - FSM states: IDLE, FILL, RUN.
//    - IDLE: pixels ignored. sof -> FILL, col=row=0.
//    - FILL: row<2. Pixels are written to the line buffers only. Leaving row 1 -> RUN.
//    - RUN: on the last pixel (col=H_ACT-1, row=V_ACT-1) -> IDLE and pulse frame_done next cycle.
//  - Pixel accept: pix_valid=1 in FILL/RUN, or sof&pix_valid in any state (that pixel is col0,row0).
//  - Counters:
//    - col increments per accepted pixel; wraps at H_ACT-1 to 0 and increments row.
//    - No blanking gaps are assumed inside a line; pix_valid may drop at any time and the window holds.
//  - Line buffers: lb1 = previous line, lb0 = line before that, both read at address col.
//    - Read-before-write: lb0[col]<=lb1[col], lb1[col]<=pix_data.
//    - Single-port inferred RAM semantics.
//  - Window: on each accept the taps shift left (c0<=c1<=c2).
//    - New column entering at c2: row0=lb0[col], row1=lb1[col], row2=pix_data.
//    - The window is not cleared at line start; the first two columns of each line are stale but masked.
//  - win_valid registered: asserted 1 cycle after an accept with row>=2 && col>=2.
//    - win_x=col-1 and win_y=row-1 of that accepted pixel.
//    - Exactly (H_ACT-2)*(V_ACT-2) strobes per complete frame.
//  - Latency: pixel accept to its window output = 1 clk.
//  - sof while FILL/RUN: abort the current frame.
//    - No frame_done; counters restart at 0; state=FILL.
//    - win_valid of the aborting cycle is suppressed.
//  - reset mid-frame: immediate return to IDLE; no frame_done.
//  - Accepts while IDLE without sof: no state change, no output.
//  - Arithmetic: col/row counters unsigned, sized $clog2(H_ACT)/$clog2(V_ACT);
//    win_x/win_y are zero-extended.
// CONFIGURATION
//  SOBEL_WIN_STATS_EN
//   - Defined: adds output win_count [19:0].
//     - An internal counter increments per win_valid and clears on sof.
//     - win_count latches the counter on frame_done and holds until the next frame_done; reset to 0.
//   - Undefined: no port, no counter. All other behaviour is identical.
// TESTING (bench uses H_ACT=4, V_ACT=3)
//  - Reset: assert reset for 3 clks, drive pix_valid=1 -> all outputs stay 0, busy=0.
//  - Frame of 12 pixels 1..12, sof with pixel 1, continuous:
//    - win_valid exactly twice.
//    - First: win_x=1, win_y=1, taps rows {1,2,3},{5,6,7},{9,10,11}.
//    - Second: win_x=2, win_y=1, taps {2,3,4},{6,7,8},{10,11,12}.
//    - frame_done 1 clk after pixel 12; busy=0 after.
//  - Same frame with pix_valid dropped for 2 clks between each pixel -> identical taps and strobes;
//    win_valid never high during gaps.
//  - sof reasserted at pixel 7 of a frame (value 100):
//    - no frame_done.
//    - 100 treated as col0,row0.
//    - the full restarted frame yields 2 strobes and one frame_done.
//  - reset at pixel 10 then pixels without sof -> no win_valid, no frame_done, busy=0.
//  - SOBEL_WIN_STATS_EN: two complete frames -> win_count=2 after each frame_done;
//    after an aborted frame, win_count is unchanged.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// 3x3 Sobel window sequencer: two line buffers, tap window, raster position.
// Optional build macro SOBEL_WIN_STATS_EN adds a per-frame window count.
module sobel_window_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sof,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic [DW-1:0] data00,
  output logic [DW-1:0] data01,
  output logic [DW-1:0] data02,
  output logic [DW-1:0] data10,
  output logic [DW-1:0] data11,
  output logic [DW-1:0] data12,
  output logic [DW-1:0] data20,
  output logic [DW-1:0] data21,
  output logic [DW-1:0] data22,
  output logic          win_valid,
  output logic [9:0]    win_x,
  output logic [8:0]    win_y,
  output logic          busy,
  output logic          frame_done
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic [19:0]   win_count
`endif
);

  localparam int CW = $clog2(H_ACT);
  localparam int RW = $clog2(V_ACT);
  localparam logic [CW-1:0] C_LAST = CW'(H_ACT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(V_ACT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row;
  logic          w_acc;
  logic          w_eol;
  logic          w_eof;
  logic          w_shift;
  logic          w_stb;
  logic          w_done;

  logic [DW-1:0] r_lb0 [H_ACT];
  logic [DW-1:0] r_lb1 [H_ACT];
  logic [DW-1:0] r_win [9];

  // A sof pixel is always position (0,0), whatever the counters hold.
  always_comb begin
    w_acc   = pix_valid & (sof | (r_state != S_IDLE));
    w_col   = sof ? '0 : r_col;
    w_row   = sof ? '0 : r_row;
    w_eol   = (w_col == C_LAST);
    w_eof   = w_eol & (w_row == R_LAST);
    w_shift = w_acc & ~sof & (r_state == S_RUN);
    w_stb   = w_shift & (w_row >= RW'(2)) & (w_col >= CW'(2));
    w_done  = w_shift & w_eof;
    w_next  = r_state;
    if (sof) begin
      w_next = S_FILL;
    end else if (w_acc) begin
      unique case (r_state)
        S_FILL: if (w_eol && w_row == RW'(1)) w_next = S_RUN;
        S_RUN:  if (w_eof) w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_win      <= '{default: '0};
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= w_stb;
      frame_done <= w_done;
      if (w_stb) begin
        win_x <= 10'(w_col - CW'(1));
        win_y <= 9'(w_row - RW'(1));
      end
      if (w_acc) begin
        r_col <= w_eol ? '0 : w_col + CW'(1);
        if (w_eol) r_row <= w_eof ? '0 : w_row + RW'(1);
        else       r_row <= w_row;
      end else if (sof) begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_shift) begin
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]   <= r_win[3*r+1];
          r_win[3*r+1] <= r_win[3*r+2];
        end
        r_win[2] <= r_lb0[w_col];
        r_win[5] <= r_lb1[w_col];
        r_win[8] <= pix_data;
      end
    end
  end

  // Read-before-write: the older line moves down as the new pixel lands.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= pix_data;
    end
  end

`ifdef SOBEL_WIN_STATS_EN
  logic [19:0] r_wcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt    <= '0;
      win_count <= '0;
    end else begin
      if (sof)        r_wcnt <= '0;
      else if (w_stb) r_wcnt <= r_wcnt + 20'd1;
      if (w_done) win_count <= r_wcnt + 20'(w_stb);
    end
  end
`endif

  assign busy   = (r_state != S_IDLE);
  assign data00 = r_win[0];
  assign data01 = r_win[1];
  assign data02 = r_win[2];
  assign data10 = r_win[3];
  assign data11 = r_win[4];
  assign data12 = r_win[5];
  assign data20 = r_win[6];
  assign data21 = r_win[7];
  assign data22 = r_win[8];

endmodule
